// File: rtl/imem_loader_pkg.sv
// Shared state encoding and boot-stream layout constants for the instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam int LEN_BYTES      = 2;
   localparam int CHK_BYTES      = 1;
   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);

   function automatic logic is_accepting(state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-memory write port; the loader takes the slave side.
interface imem_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wd;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wd
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wd
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; o_word_done flags the fourth byte.
// The word register only moves on accepts, so it stays stable while the parent writes it out.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_byte_vld,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_done
);

   logic [LANE_W-1:0] r_lane;
   logic [31:0]       r_word;

   // Shifting in from the top leaves the first byte of the word in [7:0].
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (i_clr) begin
         r_lane <= '0;
      end else if (i_byte_vld) begin
         r_word <= {i_byte, r_word[31:8]};
         r_lane <= r_lane + 1'b1;
      end
   end

   assign o_word      = r_word;
   assign o_word_done = i_byte_vld && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses length/data/checksum stream, writes words to IMEM, releases core reset on success.
// One word per 5 cycles at full rate; in_ready drops in IDLE/WRITE/DONE/ERR, stalls hold all state.
module imem_loader
   import loader_pkg::*;
#(
   parameter int MAX_WORDS = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          core_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_len;
   logic [15:0] r_word_idx;
   logic [7:0]  r_sum;

   logic        w_in_ready;
   logic        w_acc;
   logic        w_clr_ctx;
   logic        w_ld_lo;
   logic        w_ld_hi;
   logic        w_sum_add;
   logic        w_idx_inc;
   logic        w_word_done;
   logic [31:0] w_word;
   logic [15:0] w_len_full;
   logic        w_len_ok;
   logic [7:0]  w_chk_sum;
   logic        w_last_word;

   assign w_in_ready  = is_accepting(r_state);
   assign w_acc       = bus.in_valid && w_in_ready;
   assign w_len_full  = {bus.in_data, r_len[7:0]};
   assign w_len_ok    = (w_len_full != 16'd0) && ({16'd0, w_len_full} <= 32'(MAX_WORDS));
   assign w_chk_sum   = r_sum + bus.in_data;
   assign w_last_word = (r_word_idx == (r_len - 16'd1));

   word_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_ld_hi),
      .i_byte_vld  (w_acc && (r_state == DATA)),
      .i_byte      (bus.in_data),
      .o_word      (w_word),
      .o_word_done (w_word_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_clr_ctx = 1'b0;
      w_ld_lo   = 1'b0;
      w_ld_hi   = 1'b0;
      w_sum_add = 1'b0;
      w_idx_inc = 1'b0;
      unique case (r_state)
         IDLE, ERR: begin
            if (start) begin
               w_next    = LEN_LO;
               w_clr_ctx = 1'b1;
            end
         end
         LEN_LO: begin
            if (w_acc) begin
               w_ld_lo = 1'b1;
               w_next  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (w_acc) begin
               w_ld_hi   = 1'b1;
               w_clr_ctx = 1'b1;
               w_next    = w_len_ok ? DATA : ERR;
            end
         end
         DATA: begin
            if (w_acc) begin
               w_sum_add = 1'b1;
               if (w_word_done) w_next = WRITE;
            end
         end
         WRITE: begin
            if (w_last_word) begin
               w_next = CHK;
            end else begin
               w_idx_inc = 1'b1;
               w_next    = DATA;
            end
         end
         CHK: begin
            if (w_acc) w_next = (w_chk_sum == 8'd0) ? DONE : ERR;
         end
         DONE:    w_next = DONE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len      <= '0;
         r_word_idx <= '0;
         r_sum      <= '0;
      end else begin
         if (w_clr_ctx) begin
            r_word_idx <= '0;
            r_sum      <= '0;
         end
         if (w_ld_lo)   r_len[7:0]  <= bus.in_data;
         if (w_ld_hi)   r_len[15:8] <= bus.in_data;
         if (w_sum_add) r_sum       <= r_sum + bus.in_data;
         if (w_idx_inc) r_word_idx  <= r_word_idx + 16'd1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.imem_we   = (r_state == WRITE);
   assign bus.imem_addr = {14'd0, r_word_idx, 2'b00};
   assign bus.imem_wd   = w_word;
   assign busy          = w_in_ready || (r_state == WRITE);
   assign done          = (r_state == DONE);
   assign err           = (r_state == ERR);
   assign core_rst      = (r_state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes go into a queue, a negedge monitor checks them.
module tb_imem_loader;

   localparam int MAXW = 64;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wd;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic core_rst, busy, done, err;

   imem_loader_if bus ();

   imem_loader #(.MAX_WORDS(MAXW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .core_rst (core_rst),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          we_cyc[$];
   wr_t         exp_q[$];
   logic [31:0] wv[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   always @(posedge clk) cyc++;

   // Write monitor: every imem_we pulse must match the head of the expected queue.
   always @(negedge clk) begin
      wr_t e;
      if (rst && bus.imem_we === 1'b1) begin
         wr_cnt++;
         we_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr 0x%08h wd 0x%08h expected no write",
                     bus.imem_addr, bus.imem_wd);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.imem_addr, e.addr);
            check("wr_data", bus.imem_wd, e.wd);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gaps);
      if (gaps > 0) begin
         bus.in_valid = 1'b0;
         repeat (gaps) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 20 && bus.in_ready !== 1'b1; t++) @(negedge clk);
      if (bus.in_ready !== 1'b1) begin
         n_total++;
         $display("FAIL in_ready_timeout: got in_ready %b expected 1 for byte 0x%02h", bus.in_ready, b);
      end
      @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   function automatic int gap(input int gmax);
      return (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
   endfunction

   // Streams wv[0..n-1]; checksum is the two's complement of the data-byte sum plus chk_adj.
   task automatic load(input int n, input int gmax, input logic [7:0] chk_adj, input bit start_mid);
      logic [7:0] b;
      logic [7:0] sum;
      sum = 8'd0;
      pulse_start();
      send_byte(n[7:0], gap(gmax));
      send_byte(n[15:8], gap(gmax));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({32'(i * 4), wv[i]});
         for (int k = 0; k < 4; k++) begin
            b = wv[i][8*k +: 8];
            sum = sum + b;
            send_byte(b, gap(gmax));
            if (start_mid && i == 0 && k == 1) begin
               pulse_start();
               check("start_in_data_busy", {31'd0, busy}, 32'd1);
               check("start_in_data_ready", {31'd0, bus.in_ready}, 32'd1);
            end
         end
      end
      send_byte(8'(8'd0 - sum) + chk_adj, gap(gmax));
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int wr0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
      check("rst_imem_addr", bus.imem_addr, 32'd0);
      check("rst_imem_wd", bus.imem_wd, 32'd0);
      check("rst_core_rst", {31'd0, core_rst}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single-word literal stream 01 00 13 00 00 00 ED.
      wr0 = wr_cnt;
      exp_q.push_back({32'h0, 32'h0000_0013});
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'hED, 0);
      bus.in_valid = 1'b0;
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_core_rst", {31'd0, core_rst}, 32'd1);
      check("t1_err", {31'd0, err}, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd0);
      check("t1_writes", 32'(wr_cnt - wr0), 32'd1);
      pulse_start();
      @(negedge clk);
      check("start_in_done_done", {31'd0, done}, 32'd1);
      check("start_in_done_busy", {31'd0, busy}, 32'd0);
      check("start_in_done_ready", {31'd0, bus.in_ready}, 32'd0);

      // Three words with random valid gaps and a start pulse mid-word.
      do_reset();
      wr0 = wr_cnt;
      wv[0] = 32'h1122_3344; wv[1] = 32'hDEAD_BEEF; wv[2] = 32'h0000_0001;
      load(3, 3, 8'd0, 1'b1);
      @(negedge clk);
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_writes", 32'(wr_cnt - wr0), 32'd3);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // Checksum off by one, then a clean reload from ERR.
      do_reset();
      wr0 = wr_cnt;
      wv[0] = 32'hA5A5_5A5A;
      load(1, 0, 8'd1, 1'b0);
      @(negedge clk);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_core_rst", {31'd0, core_rst}, 32'd0);
      check("t3_done", {31'd0, done}, 32'd0);
      wv[0] = 32'h0BAD_F00D;
      load(1, 1, 8'd0, 1'b0);
      @(negedge clk);
      check("t3_reload_done", {31'd0, done}, 32'd1);
      check("t3_reload_err", {31'd0, err}, 32'd0);
      check("t3_writes", 32'(wr_cnt - wr0), 32'd2);

      // Zero length and MAX_WORDS+1 both abort right after the length high byte.
      do_reset();
      wr0 = wr_cnt;
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      bus.in_valid = 1'b0;
      check("t4_len0_err", {31'd0, err}, 32'd1);
      check("t4_len0_busy", {31'd0, busy}, 32'd0);
      pulse_start();
      send_byte(8'(MAXW + 1), 0); send_byte(8'h00, 0);
      bus.in_valid = 1'b0;
      check("t4_lenmax_err", {31'd0, err}, 32'd1);
      repeat (2) @(negedge clk);
      check("t4_no_writes", 32'(wr_cnt - wr0), 32'd0);

      // Reset after two of four words.
      do_reset();
      wr0 = wr_cnt;
      wv[0] = 32'h0102_0304; wv[1] = 32'hF0E0_D0C0;
      pulse_start();
      send_byte(8'h04, 0); send_byte(8'h00, 0);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({32'(i * 4), wv[i]});
         for (int k = 0; k < 4; k++) send_byte(wv[i][8*k +: 8], 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("t5_imem_we", {31'd0, bus.imem_we}, 32'd0);
      check("t5_imem_addr", bus.imem_addr, 32'd0);
      check("t5_imem_wd", bus.imem_wd, 32'd0);
      check("t5_core_rst", {31'd0, core_rst}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_done", {31'd0, done}, 32'd0);
      check("t5_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      repeat (3) @(negedge clk);
      check("t5_idle_without_start", {31'd0, busy}, 32'd0);
      check("t5_writes_before", 32'(wr_cnt - wr0), 32'd2);
      wv[0] = 32'hCAFE_F00D;
      load(1, 0, 8'd0, 1'b0);
      @(negedge clk);
      check("t5_fresh_done", {31'd0, done}, 32'd1);
      check("t5_writes_after", 32'(wr_cnt - wr0), 32'd3);

      // Continuous valid: consecutive writes five cycles apart.
      do_reset();
      we_cyc.delete();
      wv[0] = 32'h7654_3210; wv[1] = 32'h89AB_CDEF;
      load(2, 0, 8'd0, 1'b0);
      @(negedge clk);
      check("t6_done", {31'd0, done}, 32'd1);
      if (we_cyc.size() >= 2) begin
         check("t6_word_interval", 32'(we_cyc[1] - we_cyc[0]), 32'd5);
      end else begin
         n_total++;
         $display("FAIL t6_word_interval: got %0d writes expected 2", we_cyc.size());
      end
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

endmodule
